// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq: PLL lock supervisor, reconfiguration write sequencer and system reset gate
module pll_reconfig_seq #(
    parameter int STABLE_CYCLES = 1024,
    parameter int TIMEOUT       = 65535
) (
    input  logic        refclk,
    input  logic        rst_n,
    input  logic        cfg_req,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_c0,
    input  logic [17:0] cfg_c1,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        sys_reset_n
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STB_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [3:0] {
        LOCK_WAIT, RUN, WR_MODE, WR_N, WR_M, WR_C0, WR_C1, WR_START, ERR
    } state_t;

    state_t        state, nxt;
    logic          lock_m, lock_s;
    logic [SW-1:0] stb_cnt, stb_nxt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [17:0]   n_q, m_q, c0_q, c1_q;
    logic          from_cfg, from_cfg_nxt;
    logic          accept, take_req, locked_ok, timed_out;
    logic          write_nxt, busy_nxt, done_nxt, err_nxt;
    logic [5:0]    addr_nxt;
    logic [31:0]   data_nxt;

    always_comb begin
        accept    = mgmt_write && !mgmt_waitrequest;
        // loss of lock in RUN outranks a same-cycle request
        take_req  = cfg_req && (state == ERR || (state == RUN && lock_s));
        locked_ok = lock_s && stb_cnt == STB_MAX - 1'b1;
        timed_out = tmo_cnt == TMO_MAX - 1'b1;
        nxt = state;
        case (state)
            LOCK_WAIT: nxt = locked_ok ? RUN : timed_out ? ERR : LOCK_WAIT;
            RUN:       nxt = !lock_s ? LOCK_WAIT : take_req ? WR_MODE : RUN;
            ERR:       nxt = take_req ? WR_MODE : ERR;
            WR_MODE:   nxt = accept ? WR_N : WR_MODE;
            WR_N:      nxt = accept ? WR_M : WR_N;
            WR_M:      nxt = accept ? WR_C0 : WR_M;
            WR_C0:     nxt = accept ? WR_C1 : WR_C0;
            WR_C1:     nxt = accept ? WR_START : WR_C1;
            WR_START:  nxt = accept ? LOCK_WAIT : WR_START;
            default:   nxt = LOCK_WAIT;
        endcase
        stb_nxt = (state == LOCK_WAIT && lock_s) ? (stb_cnt == STB_MAX ? STB_MAX : stb_cnt + 1'b1) : '0;
        tmo_nxt = (state == LOCK_WAIT) ? (tmo_cnt == TMO_MAX ? TMO_MAX : tmo_cnt + 1'b1) : '0;
        from_cfg_nxt = (state == WR_START) || (state == LOCK_WAIT && from_cfg);
        done_nxt  = state == LOCK_WAIT && locked_ok && from_cfg;
        err_nxt   = take_req ? 1'b0 : (state == LOCK_WAIT && !locked_ok && timed_out) ? 1'b1 : cfg_err;
        busy_nxt  = !(nxt == RUN || nxt == ERR);
        write_nxt = nxt inside {WR_MODE, WR_N, WR_M, WR_C0, WR_C1, WR_START};
        addr_nxt = 6'd0;
        data_nxt = 32'd0;
        case (nxt)
            WR_N:     begin addr_nxt = 6'd3; data_nxt = {14'b0, n_q}; end
            WR_M:     begin addr_nxt = 6'd4; data_nxt = {14'b0, m_q}; end
            WR_C0:    begin addr_nxt = 6'd5; data_nxt = {9'b0, 5'd0, c0_q}; end
            WR_C1:    begin addr_nxt = 6'd5; data_nxt = {9'b0, 5'd1, c1_q}; end
            WR_START: begin addr_nxt = 6'd2; data_nxt = 32'd1; end
            default:  begin addr_nxt = 6'd0; data_nxt = 32'd0; end
        endcase
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m         <= 1'b0;
            lock_s         <= 1'b0;
            state          <= LOCK_WAIT;
            stb_cnt        <= '0;
            tmo_cnt        <= '0;
            from_cfg       <= 1'b0;
            n_q            <= '0;
            m_q            <= '0;
            c0_q           <= '0;
            c1_q           <= '0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
            cfg_busy       <= 1'b1;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            sys_reset_n    <= 1'b0;
        end else begin
            lock_m         <= pll_locked;
            lock_s         <= lock_m;
            state          <= nxt;
            stb_cnt        <= stb_nxt;
            tmo_cnt        <= tmo_nxt;
            from_cfg       <= from_cfg_nxt;
            if (take_req) begin
                n_q  <= cfg_n;
                m_q  <= cfg_m;
                c0_q <= cfg_c0;
                c1_q <= cfg_c1;
            end
            mgmt_write     <= write_nxt;
            mgmt_address   <= addr_nxt;
            mgmt_writedata <= data_nxt;
            cfg_busy       <= busy_nxt;
            cfg_done       <= done_nxt;
            cfg_err        <= err_nxt;
            sys_reset_n    <= nxt == RUN;
        end
    end
endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq: scoreboard bench for the PLL reconfiguration sequencer
module tb_pll_reconfig_seq;
    localparam int S = 8;
    localparam int T = 100;

    logic        refclk = 0, rst_n = 0, cfg_req = 0, mgmt_waitrequest = 0, pll_locked = 0;
    logic [17:0] cfg_n = 0, cfg_m = 0, cfg_c0 = 0, cfg_c1 = 0;
    logic        cfg_busy, cfg_done, cfg_err, mgmt_write, sys_reset_n;
    logic [5:0]  mgmt_address;
    logic [31:0] mgmt_writedata;

    typedef struct {logic [5:0] a; logic [31:0] d;} wr_t;
    wr_t exp_q[$];
    wr_t e;
    int  acc_cyc[$];
    int  total = 0, bad = 0, cyc = 0, n_acc = 0, done_cnt = 0, start_cyc = 0, wr_mode = 0, stall = 0;
    int  k, r, d0, n0;
    logic        stalled_prev = 0, done_prev = 0;
    logic [5:0]  prev_a = 0;
    logic [31:0] prev_d = 0;

    pll_reconfig_seq #(.STABLE_CYCLES(S), .TIMEOUT(T)) dut (
        .refclk(refclk), .rst_n(rst_n), .cfg_req(cfg_req),
        .cfg_n(cfg_n), .cfg_m(cfg_m), .cfg_c0(cfg_c0), .cfg_c1(cfg_c1),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
        .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked), .sys_reset_n(sys_reset_n)
    );

    always #5 refclk = ~refclk;
    always @(posedge refclk) cyc++;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // expected register writes for one reconfiguration, from the address map
    task automatic push_seq(input logic [17:0] n, m, c0, c1);
        exp_q.push_back('{a: 6'd0, d: 32'd0});
        exp_q.push_back('{a: 6'd3, d: 32'(n)});
        exp_q.push_back('{a: 6'd4, d: 32'(m)});
        exp_q.push_back('{a: 6'd5, d: 32'(c0)});
        exp_q.push_back('{a: 6'd5, d: 32'(c1) + 32'(1 << 18)});
        exp_q.push_back('{a: 6'd2, d: 32'd1});
    endtask

    task automatic issue_req(input logic [17:0] n, m, c0, c1, input bit acc);
        cfg_n = n; cfg_m = m; cfg_c0 = c0; cfg_c1 = c1; cfg_req = 1;
        if (acc) push_seq(n, m, c0, c1);
        @(posedge refclk); #1;
        cfg_req = 0;
        if (acc) begin
            chk("req_busy", cfg_busy, 1);
            chk("req_write", mgmt_write, 1);
            chk("req_addr", mgmt_address, 0);
            chk("req_err_clr", cfg_err, 0);
            chk("req_sysrst", sys_reset_n, 0);
        end
    endtask

    task automatic wait_q(input string name);
        int j = 0;
        while (exp_q.size() != 0 && j < 500) begin step(1); j++; end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic wait_rst(input string name, input int exp);
        int j = 0;
        while (!sys_reset_n && j < 2000) begin step(1); j++; end
        chk(name, j, exp);
    endtask

    function automatic logic [17:0] rnd();
        return 18'($urandom);
    endfunction

    always @(posedge refclk) begin
        #1;
        if (wr_mode == 1) begin
            if (mgmt_write && stall < 3) begin mgmt_waitrequest = 1; stall++; end
            else begin mgmt_waitrequest = 0; stall = 0; end
        end else mgmt_waitrequest = (wr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    always @(negedge refclk) begin
        if (!rst_n) begin
            stalled_prev = 0;
            done_prev = 0;
        end else begin
            if (mgmt_write && stalled_prev) begin
                chk("hold_addr", mgmt_address, prev_a);
                chk("hold_data", mgmt_writedata, prev_d);
            end
            if (mgmt_write && !mgmt_waitrequest) begin
                n_acc++;
                acc_cyc.push_back(cyc + 1);
                if (mgmt_address == 6'd2) start_cyc = cyc + 1;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got addr=%0d data=%0h expected no write", mgmt_address, mgmt_writedata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", mgmt_address, e.a);
                    chk("wr_data", mgmt_writedata, e.d);
                end
            end
            if (cfg_done) begin
                done_cnt++;
                chk("done_single", done_prev, 0);
                chk("done_sysrst", sys_reset_n, 1);
            end
            stalled_prev = mgmt_write && mgmt_waitrequest;
            prev_a = mgmt_address;
            prev_d = mgmt_writedata;
            done_prev = cfg_done;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(3);
        chk("rst_write", mgmt_write, 0);
        chk("rst_addr", mgmt_address, 0);
        chk("rst_data", mgmt_writedata, 0);
        chk("rst_busy", cfg_busy, 1);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_sysrst", sys_reset_n, 0);
        rst_n = 1;
        step(4);
        pll_locked = 1;
        wait_rst("powerup_lock", S + 2);
        step(2);
        chk("powerup_busy", cfg_busy, 0);
        chk("powerup_done", done_cnt, 0);

        acc_cyc.delete();
        d0 = done_cnt;
        issue_req(18'h10101, 18'h00A0A, 18'h00303, 18'h00505, 1);
        r = cyc;
        pll_locked = 0;
        step(20);
        for (int i = 0; i < 6; i++) chk("b2b_cycle", acc_cyc.size() > i ? acc_cyc[i] - r : -1, i + 1);
        chk("b2b_queue", exp_q.size(), 0);
        pll_locked = 1;
        wait_rst("cfg_relock", S + 2);
        step(2);
        chk("cfg_done_once", done_cnt - d0, 1);

        wr_mode = 1;
        n0 = n_acc;
        d0 = done_cnt;
        issue_req(rnd(), rnd(), rnd(), rnd(), 1);
        step(6);
        issue_req(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 0);
        wait_q("stall_seq");
        chk("stall_acc", n_acc - n0, 6);
        wait_rst("stall_relock", S);
        step(2);
        chk("stall_done", done_cnt - d0, 1);
        wr_mode = 0;

        d0 = done_cnt;
        pll_locked = 0;
        k = 0;
        while (sys_reset_n && k < 20) begin
            if (k == 2) cfg_req = 1;
            step(1);
            k++;
        end
        cfg_req = 0;
        chk("loss_latency", k, 3);
        chk("loss_busy", cfg_busy, 1);
        pll_locked = 1;
        step(5);
        chk("glitch_pre", sys_reset_n, 0);
        pll_locked = 0;
        step(1);
        pll_locked = 1;
        wait_rst("glitch_relock", S + 2);
        step(2);
        chk("relock_no_done", done_cnt - d0, 0);

        wr_mode = 2;
        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            issue_req(rnd(), rnd(), rnd(), rnd(), 1);
            wait_q("rand_seq");
            wait_rst("rand_relock", S);
            step(2);
            chk("rand_done", done_cnt - d0, 1);
        end
        wr_mode = 0;

        d0 = done_cnt;
        issue_req(rnd(), rnd(), rnd(), rnd(), 1);
        pll_locked = 0;
        wait_q("tmo_seq");
        k = 0;
        while (!cfg_err && k < 300) begin step(1); k++; end
        chk("tmo_cycles", cyc - start_cyc, T);
        chk("tmo_sysrst", sys_reset_n, 0);
        chk("tmo_busy", cfg_busy, 0);
        step(5);
        chk("err_sticky", cfg_err, 1);
        issue_req(rnd(), rnd(), rnd(), rnd(), 1);
        pll_locked = 1;
        wait_q("recover_seq");
        wait_rst("recover_relock", S);
        step(2);
        chk("recover_done", done_cnt - d0, 1);

        issue_req(rnd(), rnd(), rnd(), rnd(), 1);
        step(2);
        chk("wrm_write", mgmt_write, 1);
        chk("wrm_addr", mgmt_address, 4);
        #2 rst_n = 0;
        #1;
        exp_q.delete();
        chk("abort_write", mgmt_write, 0);
        chk("abort_addr", mgmt_address, 0);
        chk("abort_data", mgmt_writedata, 0);
        chk("abort_busy", cfg_busy, 1);
        chk("abort_done", cfg_done, 0);
        chk("abort_err", cfg_err, 0);
        chk("abort_sysrst", sys_reset_n, 0);
        step(2);
        rst_n = 1;
        wait_rst("reset_relock", S + 2);
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
